// File: rtl/bus_resp_pkg.sv
// Shared types and constants for the request/acknowledge byte-bus responder.
// Imported by the interface, the register file and the responder top.
package bus_resp_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 4;

    localparam logic RESP_OK  = 1'b0;
    localparam logic RESP_ERR = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // A zero-wait configuration still needs a 1-bit counter to keep widths legal.
    function automatic int cnt_width(input int waitCycles);
        int w;
        w = $clog2(waitCycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bus_ack_responder_if.sv
// Request/acknowledge byte bus between an initiator (master) and this responder (slave).
interface bus_ack_responder_if
    import bus_resp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              busy;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata, err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata, err, busy
    );

endinterface

// File: rtl/resp_regfile.sv
// DEPTH x DATA_W byte register file: synchronous write and clear, combinational read.
// Also reports whether the presented address maps onto an implemented register.
module resp_regfile
    import bus_resp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_addrOk
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [IDX_W-1:0]  w_idx;

    // Compare one bit wider so DEPTH == 2**ADDR_W does not overflow the constant.
    assign o_addrOk = ({1'b0, i_addr} < (ADDR_W + 1)'(DEPTH));
    assign w_idx    = i_addr[IDX_W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && o_addrOk) begin
            r_mem[w_idx] <= i_wdata;
        end
    end

    assign o_rdata = o_addrOk ? r_mem[w_idx] : '0;

endmodule

// File: rtl/bus_ack_responder.sv
// Responder end of the byte bus: captures a request, inserts WAIT_CYCLES wait states,
// pulses a registered ACK, then holds BUSY until the initiator releases REQ.
module bus_ack_responder
    import bus_resp_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    bus_ack_responder_if.slave   bus
);

    localparam int               CNT_W    = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            r_state;
    state_t            w_nextState;

    logic              r_holdWe;
    logic [ADDR_W-1:0] r_holdAddr;
    logic [DATA_W-1:0] r_holdWdata;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_ack;
    logic              r_err;
    logic              r_busy;
    logic [DATA_W-1:0] r_rdata;

    logic              w_capture;
    logic              w_regWe;
    logic              w_addrOk;
    logic [DATA_W-1:0] w_regRdata;
    logic              w_nextAck;
    logic              w_nextErr;
    logic              w_nextBusy;
    logic [DATA_W-1:0] w_nextRdata;

    resp_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_we     (w_regWe),
        .i_addr   (r_holdAddr),
        .i_wdata  (r_holdWdata),
        .o_rdata  (w_regRdata),
        .o_addrOk (w_addrOk)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Outputs are computed from the current state and registered, so ACK appears
    // in the cycle after the FSM sits in ACK, coinciding with the register write.
    always_comb begin
        w_nextState = r_state;
        w_capture   = 1'b0;
        w_regWe     = 1'b0;
        w_nextAck   = 1'b0;
        w_nextErr   = RESP_OK;
        w_nextRdata = '0;

        case (r_state)
            IDLE: begin
                if (bus.req) begin
                    w_capture   = 1'b1;
                    w_nextState = (WAIT_CYCLES > 0) ? WAIT : ACK;
                end
            end
            WAIT: begin
                if (!bus.req) begin
                    w_nextState = IDLE;
                end else if (r_cnt == CNT_ONE) begin
                    w_nextState = ACK;
                end
            end
            ACK: begin
                w_nextAck   = 1'b1;
                w_nextState = RELEASE;
                if (w_addrOk) begin
                    w_regWe     = r_holdWe;
                    w_nextRdata = r_holdWe ? r_holdWdata : w_regRdata;
                end else begin
                    w_nextErr = RESP_ERR;
                end
            end
            RELEASE: begin
                if (!bus.req) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        w_nextBusy = (w_nextState != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_holdWe    <= 1'b0;
            r_holdAddr  <= '0;
            r_holdWdata <= '0;
            r_cnt       <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_rdata     <= '0;
        end else begin
            if (w_capture) begin
                r_holdWe    <= bus.we;
                r_holdAddr  <= bus.addr;
                r_holdWdata <= bus.wdata;
                r_cnt       <= CNT_LOAD;
            end else if (r_state == WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
            r_ack   <= w_nextAck;
            r_err   <= w_nextErr;
            r_busy  <= w_nextBusy;
            r_rdata <= w_nextRdata;
        end
    end

    assign bus.ack   = r_ack;
    assign bus.err   = r_err;
    assign bus.busy  = r_busy;
    assign bus.rdata = r_rdata;

endmodule

// File: tb/tb_bus_ack_responder.sv
// Self-checking bench: one responder with two wait states and one with none,
// driven from a vector table plus hand-written abort, hold and reset sequences.
module tb_bus_ack_responder;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    typedef struct {
        bit we;
        int addr;
        int wdata;
        int expRdata;
        bit expErr;
    } vec_t;

    logic       clk;
    logic       rstV   [2];
    logic       reqV   [2];
    logic       weV    [2];
    logic [3:0] addrV  [2];
    logic [7:0] wdataV [2];
    logic       ackV   [2];
    logic       errV   [2];
    logic       busyV  [2];
    logic [7:0] rdataV [2];

    int   errors;
    int   checks;
    int   waitCycles [2];
    logic [7:0] model [2][16];
    exp_t sbQ [$];
    vec_t vecs [5];

    bus_ack_responder_if #(.DATA_W(8), .ADDR_W(4)) busA ();
    bus_ack_responder_if #(.DATA_W(8), .ADDR_W(4)) busB ();

    bus_ack_responder #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .WAIT_CYCLES(2)) dutA (
        .i_clk (clk),
        .i_rst (rstV[0]),
        .bus   (busA)
    );

    bus_ack_responder #(.DATA_W(8), .ADDR_W(4), .DEPTH(12), .WAIT_CYCLES(0)) dutB (
        .i_clk (clk),
        .i_rst (rstV[1]),
        .bus   (busB)
    );

    assign busA.req   = reqV[0];
    assign busA.we    = weV[0];
    assign busA.addr  = addrV[0];
    assign busA.wdata = wdataV[0];
    assign busB.req   = reqV[1];
    assign busB.we    = weV[1];
    assign busB.addr  = addrV[1];
    assign busB.wdata = wdataV[1];

    assign ackV[0]   = busA.ack;
    assign errV[0]   = busA.err;
    assign busyV[0]  = busA.busy;
    assign rdataV[0] = busA.rdata;
    assign ackV[1]   = busB.ack;
    assign errV[1]   = busB.err;
    assign busyV[1]  = busB.busy;
    assign rdataV[1] = busB.rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int sel, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s (dut %0d): got 0x%0h, expected 0x%0h", name, sel, act, expv);
        end
    endtask

    // Full transaction: drive, scramble inputs after capture, wait for ACK, release REQ.
    task automatic applyStimulus(input int sel, input bit we, input int addr, input int wdata,
                                 input int expRdata, input bit expErr);
        exp_t e;
        int   lat;
        bit   seen;
        @(negedge clk);
        reqV[sel]   = 1'b1;
        weV[sel]    = we;
        addrV[sel]  = 4'(addr);
        wdataV[sel] = 8'(wdata);
        e.rdata = 8'(expRdata);
        e.err   = expErr;
        sbQ.push_back(e);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            lat = c;
            if (c == 1) begin
                checkOutput("busyAfterCapture", sel, 32'(busyV[sel]), 32'd1);
                weV[sel]    = ~we;
                addrV[sel]  = ~4'(addr);
                wdataV[sel] = ~8'(wdata);
            end
            if (ackV[sel]) seen = 1'b1;
        end
        if (!seen) begin
            checkOutput("ackTimeout", sel, 32'd0, 32'd1);
            void'(sbQ.pop_front());
        end else begin
            e = sbQ.pop_front();
            checkOutput("ackLatency", sel, 32'(lat), 32'(2 + waitCycles[sel]));
            checkOutput("rdata", sel, 32'(rdataV[sel]), 32'(e.rdata));
            checkOutput("err", sel, 32'(errV[sel]), 32'(e.err));
            checkOutput("busyAtAck", sel, 32'(busyV[sel]), 32'd1);
            @(negedge clk);
            checkOutput("ackSinglePulse", sel, 32'(ackV[sel]), 32'd0);
            checkOutput("rdataAfterAck", sel, 32'(rdataV[sel]), 32'd0);
        end
        reqV[sel] = 1'b0;
        @(negedge clk);
        checkOutput("busyAfterRelease", sel, 32'(busyV[sel]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        int   ackCnt;
        int   busyLow;
        bit   seen;

        errors = 0;
        checks = 0;
        waitCycles[0] = 2;
        waitCycles[1] = 0;
        for (int s = 0; s < 2; s++) begin
            rstV[s] = 1'b1; reqV[s] = 1'b0; weV[s] = 1'b0; addrV[s] = '0; wdataV[s] = '0;
            for (int a = 0; a < 16; a++) model[s][a] = 8'h00;
        end

        vecs[0] = '{we: 1'b1, addr: 3,  wdata: 'hA5, expRdata: 'hA5, expErr: 1'b0};
        vecs[1] = '{we: 1'b0, addr: 3,  wdata: 'h00, expRdata: 'hA5, expErr: 1'b0};
        vecs[2] = '{we: 1'b0, addr: 4,  wdata: 'h00, expRdata: 'h00, expErr: 1'b0};
        vecs[3] = '{we: 1'b1, addr: 14, wdata: 'h3C, expRdata: 'h00, expErr: 1'b1};
        vecs[4] = '{we: 1'b0, addr: 12, wdata: 'h00, expRdata: 'h00, expErr: 1'b1};

        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checkOutput("resetAck", s, 32'(ackV[s]), 32'd0);
            checkOutput("resetBusy", s, 32'(busyV[s]), 32'd0);
            checkOutput("resetErr", s, 32'(errV[s]), 32'd0);
            checkOutput("resetRdata", s, 32'(rdataV[s]), 32'd0);
        end
        rstV[0] = 1'b0;
        rstV[1] = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].expRdata, vecs[i].expErr);
            if (vecs[i].we && vecs[i].addr < 12) model[0][vecs[i].addr] = 8'(vecs[i].wdata);
        end
        for (int a = 0; a < 12; a++) begin
            applyStimulus(0, 1'b0, a, 0, int'(model[0][a]), 1'b0);
        end

        // Abort: REQ dropped after one WAIT cycle must leave no trace.
        @(negedge clk);
        reqV[0] = 1'b1; weV[0] = 1'b1; addrV[0] = 4'd5; wdataV[0] = 8'h77;
        @(negedge clk);
        @(negedge clk);
        reqV[0] = 1'b0;
        ackCnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ackV[0]) ackCnt++;
        end
        checkOutput("abortNoAck", 0, 32'(ackCnt), 32'd0);
        checkOutput("abortBusy", 0, 32'(busyV[0]), 32'd0);
        applyStimulus(0, 1'b0, 5, 0, int'(model[0][5]), 1'b0);

        // Held REQ: one ACK only, BUSY stays high until REQ drops.
        @(negedge clk);
        reqV[0] = 1'b1; weV[0] = 1'b0; addrV[0] = 4'd3; wdataV[0] = 8'h00;
        e.rdata = model[0][3];
        e.err   = 1'b0;
        sbQ.push_back(e);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (ackV[0]) seen = 1'b1;
        end
        if (!seen) begin
            checkOutput("heldAckTimeout", 0, 32'd0, 32'd1);
            void'(sbQ.pop_front());
        end else begin
            e = sbQ.pop_front();
            checkOutput("heldRdata", 0, 32'(rdataV[0]), 32'(e.rdata));
        end
        ackCnt  = seen ? 1 : 0;
        busyLow = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (ackV[0]) ackCnt++;
            if (!busyV[0]) busyLow++;
        end
        checkOutput("heldAckCount", 0, 32'(ackCnt), 32'd1);
        checkOutput("heldBusyDrops", 0, 32'(busyLow), 32'd0);
        reqV[0] = 1'b0;
        applyStimulus(0, 1'b0, 3, 0, int'(model[0][3]), 1'b0);

        // Reset during WAIT of a write: aborted, and all registers cleared.
        @(negedge clk);
        reqV[0] = 1'b1; weV[0] = 1'b1; addrV[0] = 4'd3; wdataV[0] = 8'h11;
        @(negedge clk);
        rstV[0] = 1'b1;
        @(negedge clk);
        checkOutput("midResetAck", 0, 32'(ackV[0]), 32'd0);
        checkOutput("midResetBusy", 0, 32'(busyV[0]), 32'd0);
        checkOutput("midResetErr", 0, 32'(errV[0]), 32'd0);
        checkOutput("midResetRdata", 0, 32'(rdataV[0]), 32'd0);
        rstV[0] = 1'b0;
        reqV[0] = 1'b0;
        for (int a = 0; a < 16; a++) model[0][a] = 8'h00;
        applyStimulus(0, 1'b0, 3, 0, int'(model[0][3]), 1'b0);

        // Zero wait states: immediate ACK, and a quick REQ drop cannot abort.
        applyStimulus(1, 1'b1, 3, 'hA5, 'hA5, 1'b0);
        model[1][3] = 8'hA5;
        @(negedge clk);
        reqV[1] = 1'b1; weV[1] = 1'b1; addrV[1] = 4'd5; wdataV[1] = 8'h77;
        e.rdata = 8'h77;
        e.err   = 1'b0;
        sbQ.push_back(e);
        @(negedge clk);
        reqV[1] = 1'b0;
        @(negedge clk);
        e = sbQ.pop_front();
        checkOutput("noWaitAck", 1, 32'(ackV[1]), 32'd1);
        checkOutput("noWaitRdata", 1, 32'(rdataV[1]), 32'(e.rdata));
        checkOutput("noWaitErr", 1, 32'(errV[1]), 32'(e.err));
        model[1][5] = 8'h77;
        @(negedge clk);
        checkOutput("noWaitBusyIdle", 1, 32'(busyV[1]), 32'd0);
        applyStimulus(1, 1'b0, 5, 0, int'(model[1][5]), 1'b0);
        applyStimulus(1, 1'b0, 3, 0, int'(model[1][3]), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
